instr_fetch_reg: RTL and testbench
==================================

// Module: instr_fetch_reg
// PURPOSE
//   Instruction register and field splitter between the instruction memory read port and the control FSM.
//   Captures the memory word once nextInstruction has been held for MEM_LATENCY cycles.
//   Presents opCode1/opCode2/conditionCode/shiftAmtIn and register indices from the held word.
//   Owns the extended-immediate register, loaded on immediateRegEN with zero/sign extension per zeroExtend.
// PARAMETERS
//   DATA_WIDTH   16  instruction / immediate width (fields below assume 16)
//   MEM_LATENCY  2   consecutive nextInstruction-high cycles before capture; legal 1..7
//   CNT_WIDTH    16  width of retired-fetch counter fetchCount
// PORTS
//   clk             in   1           rising-edge clock
//   reset           in   1           asynchronous, active-low reset
//   memQ            in   DATA_WIDTH  instruction memory read data
//   nextInstruction in   1           fetch request level from control FSM
//   immediateRegEN  in   1           load immediate register this cycle
//   zeroExtend      in   1           1: zero-extend imm8, 0: sign-extend imm8
//   instr           out  DATA_WIDTH  held instruction word
//   opCode1         out  4           instr[15:12]
//   conditionCode   out  4           instr[11:8] (also Rdest index)
//   opCode2         out  4           instr[7:4]
//   shiftAmtIn      out  4           instr[3:0] (also Rsrc index)
//   rDest, rSrc     out  4 each      instr[11:8], instr[3:0]
//   immediate       out  DATA_WIDTH  extended immediate register
//   instrValid      out  1           held word is a completed capture
//   fetchAbort      out  1           one-cycle pulse: request dropped before capture
//   fetchCount      out  CNT_WIDTH   number of completed captures, wraps
// BEHAVIOUR
//   Reset (async, reset==0): state=IDLE, cnt=0, instr=0, immediate=0, instrValid=0, fetchAbort=0, fetchCount=0.
//   Field outputs are combinational slices of registered instr; no extra latency.
//   States: IDLE, WAIT, HOLD. cnt counts sampled-high cycles of nextInstruction.
//   IDLE/HOLD, nI=1: if MEM_LATENCY==1 capture now -> HOLD; else cnt<=1 -> WAIT; instrValid<=0.
//   IDLE/HOLD, nI=0: stay; outputs held.
//   WAIT, nI=1: cnt<=cnt+1; when cnt+1==MEM_LATENCY capture -> HOLD, cnt<=0.
//   WAIT, nI=0: -> IDLE, cnt<=0, fetchAbort=1 for next cycle, instr unchanged, instrValid stays 0.
//   Capture edge: instr<=memQ, instrValid<=1, fetchCount<=fetchCount+1 (mod 2^CNT_WIDTH).
//   nI held high continuously: capture every MEM_LATENCY cycles (HOLD restarts WAIT).
//   immediateRegEN=1: immediate <= zeroExtend ? {8'h00,instr[7:0]} : {{8{instr[7]}},instr[7:0]}.
//   Same-edge capture + immediateRegEN: immediate uses pre-capture instr.
//   immediateRegEN=0: immediate holds. immediate is independent of state.
//   Reset asserted mid-WAIT: immediate return to reset values; no abort pulse.
//   With control FSM FETCH,FETCH2,DECODE and MEM_LATENCY=2: capture at end of FETCH2,
//   fields valid throughout DECODE.
// TESTING
//   Reset mid-WAIT (cnt=1) -> all outputs 0, state IDLE, no fetchAbort.
//   memQ=16'h5A3F, nI high 2 cycles -> instr=5A3F, opCode1=5, cond=A, opCode2=3, shift=F,
//     instrValid=1, fetchCount=1.
//   instr=16'h5A80, immediateRegEN, zeroExtend=0 -> immediate=FF80; zeroExtend=1 -> 0080.
//   nI high 1 cycle then low (MEM_LATENCY=2) -> fetchAbort pulse 1 cycle, instr unchanged,
//     fetchCount unchanged.
//   nI held high 6 cycles, memQ stepping 1,2,3.. -> 3 captures, fetchCount=3, instrValid low
//     in each restart cycle.
//   fetchCount preset near wrap (CNT_WIDTH=4, 15 captures) + 1 capture -> fetchCount=0;
//     same-edge capture+immediateRegEN loads from old instr.

Source files
------------

// File: rtl/instr_fetch_reg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_reg
//  Description : Instruction register and field splitter between the
//                instruction memory read port and the control FSM. Captures
//                memQ once nextInstruction has been held for MEM_LATENCY
//                cycles, exposes instruction fields, owns the extended
//                immediate register and counts completed fetches.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_reg #(
    parameter int DATA_WIDTH  = 16,
    parameter int MEM_LATENCY = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] memQ,
    input  logic                  nextInstruction,
    input  logic                  immediateRegEN,
    input  logic                  zeroExtend,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [3:0]            opCode1,
    output logic [3:0]            conditionCode,
    output logic [3:0]            opCode2,
    output logic [3:0]            shiftAmtIn,
    output logic [3:0]            rDest,
    output logic [3:0]            rSrc,
    output logic [DATA_WIDTH-1:0] immediate,
    output logic                  instrValid,
    output logic                  fetchAbort,
    output logic [CNT_WIDTH-1:0]  fetchCount
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Latency as a counter-width constant; legal range 1..7 fits in 4 bits.
    localparam logic [3:0] C_LAT = 4'(MEM_LATENCY);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic [DATA_WIDTH-1:0]   imm_q, imm_d;
    logic                    valid_q, valid_d;
    logic                    abort_q, abort_d;
    logic [CNT_WIDTH-1:0]    count_q, count_d;
    logic                    w_capture;

    // Fetch sequencing: count sampled-high request cycles and decide capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        abort_d   = 1'b0;
        w_capture = 1'b0;
        case (state_q)
            S_IDLE, S_HOLD: begin
                if (nextInstruction) begin
                    valid_d = 1'b0;
                    if (C_LAT == 4'd1) begin
                        w_capture = 1'b1;
                        state_d   = S_HOLD;
                    end else begin
                        cnt_d   = 4'd1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (nextInstruction) begin
                    if (cnt_q + 4'd1 == C_LAT) begin
                        w_capture = 1'b1;
                        cnt_d     = 4'd0;
                        state_d   = S_HOLD;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    // Request withdrawn before the memory word was ready.
                    cnt_d   = 4'd0;
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Capture datapath and immediate extension; immediate always sees the
    // pre-capture word because it reads the registered instr_q.
    always_comb begin
        instr_d = instr_q;
        count_d = count_q;
        imm_d   = imm_q;
        if (w_capture) begin
            instr_d = memQ;
            count_d = count_q + 1'b1;
        end
        if (immediateRegEN) begin
            imm_d = zeroExtend ? {{(DATA_WIDTH-8){1'b0}}, instr_q[7:0]}
                               : {{(DATA_WIDTH-8){instr_q[7]}}, instr_q[7:0]};
        end
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            instr_q <= '0;
            imm_q   <= '0;
            valid_q <= 1'b0;
            abort_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            imm_q   <= imm_d;
            valid_q <= w_capture ? 1'b1 : valid_d;
            abort_q <= abort_d;
            count_q <= count_d;
        end
    end

    assign instr         = instr_q;
    assign opCode1       = instr_q[15:12];
    assign conditionCode = instr_q[11:8];
    assign opCode2       = instr_q[7:4];
    assign shiftAmtIn    = instr_q[3:0];
    assign rDest         = instr_q[11:8];
    assign rSrc          = instr_q[3:0];
    assign immediate     = imm_q;
    assign instrValid    = valid_q;
    assign fetchAbort    = abort_q;
    assign fetchCount    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_reg
//  Description : Self-checking bench for instr_fetch_reg against a streak-
//                based reference model of the fetch protocol.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_reg;

    localparam int ML = 2;
    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] memQ = '0;
    logic        nI = 1'b0;
    logic        imm_en = 1'b0;
    logic        zx = 1'b0;
    logic [15:0] instr, immediate;
    logic [3:0]  opCode1, conditionCode, opCode2, shiftAmtIn, rDest, rSrc;
    logic        instrValid, fetchAbort;
    logic [CW-1:0] fetchCount;

    int checks = 0;
    int errors = 0;

    // Reference model: a fetch completes whenever the run of consecutive
    // high request cycles reaches a multiple of the memory latency.
    logic [15:0]   m_instr = '0, m_imm = '0;
    logic          m_valid = 1'b0, m_abort = 1'b0;
    logic [CW-1:0] m_count = '0;
    int            streak = 0;

    instr_fetch_reg #(.DATA_WIDTH(16), .MEM_LATENCY(ML), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .memQ(memQ), .nextInstruction(nI),
        .immediateRegEN(imm_en), .zeroExtend(zx), .instr(instr),
        .opCode1(opCode1), .conditionCode(conditionCode), .opCode2(opCode2),
        .shiftAmtIn(shiftAmtIn), .rDest(rDest), .rSrc(rSrc),
        .immediate(immediate), .instrValid(instrValid), .fetchAbort(fetchAbort),
        .fetchCount(fetchCount)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_instr = '0; m_imm = '0; m_valid = 1'b0; m_abort = 1'b0;
        m_count = '0; streak = 0;
    endtask

    // Advance one clock and update the model from the inputs it sampled.
    task automatic tick();
        logic [15:0] old;
        bit cap, ab;
        @(posedge clk);
        old = m_instr;
        cap = nI && (((streak + 1) % ML) == 0);
        ab  = !nI && ((streak % ML) != 0);
        streak = nI ? streak + 1 : 0;
        if (imm_en) m_imm = zx ? {8'h00, old[7:0]} : {{8{old[7]}}, old[7:0]};
        if (cap) begin
            m_instr = memQ; m_valid = 1'b1; m_count = m_count + 1'b1;
        end else if (nI) begin
            m_valid = 1'b0;
        end
        m_abort = ab;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++;
        if ({instr, immediate, instrValid, fetchAbort, fetchCount} !== '0) begin
            errors++;
            $display("FAIL reset_state: instr=%h imm=%h valid=%b abort=%b cnt=%h required all 0",
                     instr, immediate, instrValid, fetchAbort, fetchCount);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_capture();
        nI = 1'b0; tick();
        memQ = 16'h5A3F; nI = 1'b1; tick(); tick();
        nI = 1'b0;
        checks++;
        if (instr !== 16'h5A3F || {opCode1, conditionCode, opCode2, shiftAmtIn} !== 16'h5A3F ||
            {rDest, rSrc} !== 8'hAF) begin
            errors++;
            $display("FAIL capture_fields: instr=%h op1=%h cc=%h op2=%h sh=%h rd=%h rs=%h required 5A3F 5 A 3 F A F",
                     instr, opCode1, conditionCode, opCode2, shiftAmtIn, rDest, rSrc);
        end
        checks++;
        if (instrValid !== 1'b1 || fetchCount !== 4'd1) begin
            errors++;
            $display("FAIL capture_valid_count: valid=%b cnt=%0d required 1 1", instrValid, fetchCount);
        end
    endtask

    task automatic test_immediate();
        memQ = 16'h5A80; nI = 1'b1; tick(); tick(); nI = 1'b0;
        imm_en = 1'b1; zx = 1'b0; tick();
        checks++;
        if (immediate !== 16'hFF80 || m_imm !== 16'hFF80) begin
            errors++;
            $display("FAIL imm_sign: imm=%h required FF80", immediate);
        end
        zx = 1'b1; tick();
        checks++;
        if (immediate !== 16'h0080) begin
            errors++;
            $display("FAIL imm_zero: imm=%h required 0080", immediate);
        end
        imm_en = 1'b0; zx = 1'b0; memQ = 16'h1234; tick();
        checks++;
        if (immediate !== 16'h0080) begin
            errors++;
            $display("FAIL imm_hold: imm=%h required 0080", immediate);
        end
    endtask

    task automatic test_abort();
        logic [15:0]   i0;
        logic [CW-1:0] c0;
        nI = 1'b0; tick();
        i0 = instr; c0 = fetchCount;
        memQ = 16'hDEAD; nI = 1'b1; tick();
        nI = 1'b0; tick();
        checks++;
        if (fetchAbort !== 1'b1 || instr !== m_instr || fetchCount !== c0 || instr !== i0) begin
            errors++;
            $display("FAIL abort_pulse: abort=%b instr=%h cnt=%0d required 1 %h %0d",
                     fetchAbort, instr, fetchCount, i0, c0);
        end
        checks++;
        if (instrValid !== 1'b0) begin
            errors++;
            $display("FAIL abort_valid: valid=%b required 0", instrValid);
        end
        tick();
        checks++;
        if (fetchAbort !== 1'b0) begin
            errors++;
            $display("FAIL abort_one_cycle: abort=%b required 0", fetchAbort);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]    vseen;
        logic [CW-1:0] c0;
        c0 = fetchCount;
        nI = 1'b1;
        for (int i = 0; i < 6; i++) begin
            memQ = 16'(i + 1);
            tick();
            vseen[i] = instrValid;
        end
        nI = 1'b0;
        checks++;
        if (vseen !== 6'b101010) begin
            errors++;
            $display("FAIL b2b_valid_pattern: got %b required 101010 (cycle0 at lsb)", vseen);
        end
        checks++;
        if (fetchCount !== CW'(c0 + 3) || instr !== 16'd6) begin
            errors++;
            $display("FAIL b2b_count: cnt=%0d instr=%h required %0d 0006", fetchCount, instr, CW'(c0 + 3));
        end
    endtask

    task automatic test_wrap();
        nI = 1'b0; tick();
        for (int k = 0; k < 20 && m_count != 4'd15; k++) begin
            memQ = 16'h12C4; nI = 1'b1; tick(); tick(); nI = 1'b0;
        end
        checks++;
        if (fetchCount !== 4'd15 || instr !== 16'h12C4) begin
            errors++;
            $display("FAIL wrap_preset: cnt=%0d instr=%h required 15 12C4", fetchCount, instr);
        end
        memQ = 16'hABCD; nI = 1'b1; tick();
        imm_en = 1'b1; zx = 1'b0; tick();
        imm_en = 1'b0; nI = 1'b0;
        checks++;
        if (fetchCount !== 4'd0 || instr !== 16'hABCD) begin
            errors++;
            $display("FAIL wrap_count: cnt=%0d instr=%h required 0 ABCD", fetchCount, instr);
        end
        checks++;
        if (immediate !== 16'hFFC4) begin
            errors++;
            $display("FAIL same_edge_imm: imm=%h required FFC4", immediate);
        end
    endtask

    task automatic test_reset_mid_wait();
        nI = 1'b0; tick();
        memQ = 16'h7777; nI = 1'b1; tick();
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({instr, immediate, instrValid, fetchAbort, fetchCount} !== '0) begin
            errors++;
            $display("FAIL reset_mid_wait: instr=%h imm=%h valid=%b abort=%b cnt=%h required all 0",
                     instr, immediate, instrValid, fetchAbort, fetchCount);
        end
        @(posedge clk); #1;
        nI = 1'b0; reset = 1'b1;
        tick();
        checks++;
        if (fetchAbort !== 1'b0 || instrValid !== 1'b0 || instr !== 16'h0) begin
            errors++;
            $display("FAIL reset_no_abort: abort=%b valid=%b instr=%h required 0 0 0000",
                     fetchAbort, instrValid, instr);
        end
        nI = 1'b1; tick();
        checks++;
        if (instrValid !== 1'b0 || fetchCount !== 4'd0) begin
            errors++;
            $display("FAIL reset_restart_early: valid=%b cnt=%0d required 0 0", instrValid, fetchCount);
        end
        tick(); nI = 1'b0;
        checks++;
        if (instrValid !== 1'b1 || instr !== 16'h7777 || fetchCount !== 4'd1) begin
            errors++;
            $display("FAIL reset_restart: valid=%b instr=%h cnt=%0d required 1 7777 1",
                     instrValid, instr, fetchCount);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            nI     = ($urandom_range(0, 3) != 0);
            memQ   = 16'($urandom);
            imm_en = ($urandom_range(0, 2) == 0);
            zx     = 1'($urandom);
            tick();
            checks++;
            if (instr !== m_instr || immediate !== m_imm || instrValid !== m_valid ||
                fetchAbort !== m_abort || fetchCount !== m_count) begin
                errors++;
                $display("FAIL rand_cycle%0d: instr=%h imm=%h v=%b ab=%b cnt=%0d required %h %h %b %b %0d",
                         i, instr, immediate, instrValid, fetchAbort, fetchCount,
                         m_instr, m_imm, m_valid, m_abort, m_count);
            end
            checks++;
            if ({opCode1, conditionCode, opCode2, shiftAmtIn} !== m_instr ||
                {rDest, rSrc} !== {m_instr[11:8], m_instr[3:0]}) begin
                errors++;
                $display("FAIL rand_fields%0d: fields=%h%h%h%h rd=%h rs=%h required %h",
                         i, opCode1, conditionCode, opCode2, shiftAmtIn, rDest, rSrc, m_instr);
            end
        end
        nI = 1'b0; imm_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_capture();
        test_immediate();
        test_abort();
        test_back_to_back();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
